ultra_sonic_scan: RTL and testbench
===================================

ULTRA_SONIC_SCAN -- requirements
Module: ultra_sonic_scan

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of ultrasonic sensor channels (1..8).
REQ-002 SHALL have parameter TRIG_CYC, default 1500, trigger pulse width in clk cycles (15 us at 100 MHz).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 2500000, echo timeout in clk cycles (25 ms), measured from trigger end.
REQ-004 SHALL have parameter GAP_CYC, default 6000000, quiet time in clk cycles after each channel result (60 ms).
REQ-005 SHALL have parameter CNT_W, default 22, echo count width.
REQ-006 SHALL have parameter CH_W, default 1, channel index width, equal to max(1, clog2(N_CH)).
REQ-007 Ports: clk  in  1  single clock, rising edge.
REQ-008 Ports: reset  in  1  asynchronous, active-low (0 = reset).
REQ-009 Ports: start  in  1  one-cycle request to begin a sweep.
REQ-010 Ports: mode  in  1  0 = single sweep, 1 = continuous sweeps.
REQ-011 Ports: echo  in  N_CH  raw asynchronous echo pins.
REQ-012 Ports: trig  out  N_CH  trigger pins, at most one bit high at a time.
REQ-013 Ports: busy  out  1  high whenever state is not IDLE.
REQ-014 Ports: result_valid  out  1  one-cycle pulse, result fields valid.
REQ-015 Ports: result_ch  out  CH_W  channel of the current result.
REQ-016 Ports: result_cnt  out  CNT_W  echo high time in clk cycles.
REQ-017 Ports: result_timeout  out  1  result ended by timeout.

Function
REQ-018 Each echo bit SHALL pass a 2-flop synchroniser, then a third flop for edge detection; only synchronised echo of the selected channel is used.
REQ-019 FSM states SHALL be IDLE, TRIG, WAIT_HI, MEAS, GAP.
REQ-020 IDLE: start=1 -> TRIG, ch=0; start while not IDLE SHALL be ignored.
REQ-021 TRIG: trig[ch]=1 for exactly TRIG_CYC cycles, then WAIT_HI with timeout timer cleared to 0.
REQ-022 WAIT_HI: synchronised rising edge of echo[ch] -> MEAS with echo count cleared; a stuck-high echo without a rising edge SHALL NOT start MEAS.
REQ-023 MEAS: echo count SHALL increment each cycle the synchronised echo is high, saturating at 2^CNT_W-1.
REQ-024 MEAS: synchronised echo low -> GAP, result_timeout=0.
REQ-025 Timer SHALL increment in WAIT_HI and MEAS; timer = TIMEOUT_CYC-1 -> GAP, result_timeout=1, result_cnt = current count (0 if from WAIT_HI).
REQ-026 Result fields SHALL be registered on the transition into GAP; result_valid SHALL be high for exactly the first GAP cycle; fields hold until the next result.
REQ-027 GAP: after GAP_CYC cycles, ch<N_CH-1 -> ch+1, TRIG.
REQ-028 GAP: after GAP_CYC cycles, last channel with mode=1 -> ch=0, TRIG.
REQ-029 GAP: after GAP_CYC cycles, last channel with mode=0 -> IDLE; mode SHALL be sampled only at this decision.
REQ-030 Echo activity on unselected channels SHALL have no effect.

Reset
REQ-031 reset=0 SHALL immediately force state=IDLE, ch=0, timer=0, count=0, all synchroniser flops=0, trig=0, busy=0, result_valid=0, result_ch=0, result_cnt=0, result_timeout=0.
REQ-032 Reset asserted mid-operation SHALL abort without emitting result_valid; the first start after release SHALL begin at ch=0.

Structure
REQ-033 Package ultra_sonic_pkg SHALL hold the FSM state encoding and default timing constants.
REQ-034 Sub-module ultra_sonic_sync SHALL implement one channel of synchroniser plus rise/fall detect, instantiated N_CH times.

Verification (N_CH=2, TRIG_CYC=4, TIMEOUT_CYC=100, GAP_CYC=10, CNT_W=8)
REQ-035 Reset released, no stimulus -> trig=00, busy=0, result_valid=0 for 200 cycles.
REQ-036 start, mode=0, echo[0] high 20 cycles starting 5 cycles after trig[0] falls, echo[1] silent -> {ch0,cnt 20,to 0}, then {ch1,cnt 0,to 1}, busy falls.
REQ-037 echo[0] held high from before start -> ch0 result cnt 0, timeout 1; echo[0] rising then never falling -> ch0 timeout 1, cnt>0.
REQ-038 mode=1, echo pulses 10/30 cycles on ch0/ch1 -> results ch0,ch1,ch0,ch1 with cnt 10,30,10,30.
REQ-039 Reset pulled low during MEAS, then start -> no stale result_valid; trig[0] is first trigger.
REQ-040 start pulse during GAP and echo[1] pulse while ch=0 -> no extra sweep; ch0 result unaffected.

Source files
------------

// File: rtl/ultra_sonic_pkg.sv
// Shared types and timing defaults for the ultrasonic scanner.
// No ports: FSM state encoding, default constants, width helper.
package ultra_sonic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_HI,
    S_MEAS,
    S_GAP
  } state_t;

  localparam int DEF_N_CH        = 2;
  localparam int DEF_TRIG_CYC    = 1500;
  localparam int DEF_TIMEOUT_CYC = 2500000;
  localparam int DEF_GAP_CYC     = 6000000;
  localparam int DEF_CNT_W       = 22;
  localparam int TMR_W           = 32;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ultra_sonic_scan_if.sv
// Control/result bundle of the ultrasonic scanner.
// master: scanner (drives busy/result_*); slave: host (drives start/mode).
import ultra_sonic_pkg::*;

interface ultra_sonic_scan_if #(
  parameter int CH_W  = 1,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic             mode;
  logic             busy;
  logic             result_valid;
  logic [CH_W-1:0]  result_ch;
  logic [CNT_W-1:0] result_cnt;
  logic             result_timeout;

  modport master (
    input  start, mode,
    output busy, result_valid, result_ch,
    output result_cnt, result_timeout
  );

  modport slave (
    output start, mode,
    input  busy, result_valid, result_ch,
    input  result_cnt, result_timeout
  );

endinterface

// File: rtl/ultra_sonic_sync.sv
// One echo channel: 2-flop synchroniser plus edge-detect flop.
// Ports: clk, reset (async low), echo_i raw; lvl_o/rise_o/fall_o synced.
module ultra_sonic_sync (
  input  logic clk,
  input  logic reset,
  input  logic echo_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;

  always_comb begin
    s1_d = echo_i;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/ultra_sonic_scan.sv
// Multi-channel ultrasonic ranger: trigger, time echo, report per channel.
// Ports: clk, reset (async low), echo/trig per channel, bus = control/results.
module ultra_sonic_scan
  import ultra_sonic_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int TRIG_CYC    = DEF_TRIG_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CH_W        = ch_w(N_CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CH-1:0]     echo,
  output logic [N_CH-1:0]     trig,
  ultra_sonic_scan_if.master  bus
);

  localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIG_CYC - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYC - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

  state_t           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rv_q, rv_d;
  logic [CH_W-1:0]  rch_q, rch_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             rto_q, rto_d;

  logic [N_CH-1:0]  lvl, rise, fall;
  logic             sel_lvl, sel_rise, sel_fall;
  logic             go_gap, gap_to;
  logic [CNT_W-1:0] gap_cnt;

  for (genvar i = 0; i < N_CH; i++) begin : g_sync
    ultra_sonic_sync u_sync (
      .clk    (clk),
      .reset  (reset),
      .echo_i (echo[i]),
      .lvl_o  (lvl[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  always_comb begin
    sel_lvl  = 1'b0;
    sel_rise = 1'b0;
    sel_fall = 1'b0;
    trig     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        sel_lvl  = lvl[i];
        sel_rise = rise[i];
        sel_fall = fall[i];
        trig[i]  = (state_q == S_TRIG);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;
    rch_d   = rch_q;
    rcnt_d  = rcnt_q;
    rto_d   = rto_q;
    go_gap  = 1'b0;
    gap_to  = 1'b0;
    gap_cnt = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_TRIG;
          ch_d    = '0;
          tmr_d   = '0;
        end
      end
      S_TRIG: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TRIG_LAST) begin
          state_d = S_WAIT_HI;
          tmr_d   = '0;
          cnt_d   = '0;
        end
      end
      S_WAIT_HI: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TO_LAST) begin
          go_gap = 1'b1;
          gap_to = 1'b1;
        end else if (sel_rise) begin
          // The rise cycle is already one high cycle of the pulse.
          state_d = S_MEAS;
          cnt_d   = CNT_W'(1);
        end
      end
      S_MEAS: begin
        tmr_d = tmr_q + 1'b1;
        if (sel_lvl && cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (tmr_q == TO_LAST) begin
          go_gap  = 1'b1;
          gap_to  = 1'b1;
          gap_cnt = cnt_q;
        end else if (sel_fall) begin
          go_gap  = 1'b1;
          gap_cnt = cnt_q;
        end
      end
      S_GAP: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          state_d = S_TRIG;
          if (ch_q != CH_LAST) begin
            ch_d = ch_q + CH_W'(1);
          end else if (bus.mode) begin
            ch_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go_gap) begin
      state_d = S_GAP;
      tmr_d   = '0;
      rv_d    = 1'b1;
      rch_d   = ch_q;
      rcnt_d  = gap_cnt;
      rto_d   = gap_to;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rch_q   <= '0;
      rcnt_q  <= '0;
      rto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rch_q   <= rch_d;
      rcnt_q  <= rcnt_d;
      rto_q   <= rto_d;
    end
  end

  assign bus.busy           = (state_q != S_IDLE);
  assign bus.result_valid   = rv_q;
  assign bus.result_ch      = rch_q;
  assign bus.result_cnt     = rcnt_q;
  assign bus.result_timeout = rto_q;

endmodule

// File: tb/tb_ultra_sonic_scan.sv
// Scoreboard bench for ultra_sonic_scan (N_CH=2, small timing).
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_ultra_sonic_scan;

  logic       clk;
  logic       reset;
  logic [1:0] echo;
  logic [1:0] trig;

  ultra_sonic_scan_if #(.CH_W(1), .CNT_W(8)) bus ();

  ultra_sonic_scan #(
    .N_CH(2), .TRIG_CYC(4), .TIMEOUT_CYC(100),
    .GAP_CYC(10), .CNT_W(8), .CH_W(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .echo  (echo),
    .trig  (trig),
    .bus   (bus)
  );

  typedef struct packed {
    logic       ch;
    logic [7:0] cnt;
    logic       to;
    logic       any;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic exp_push(input logic c, input logic [7:0] n,
                          input logic t, input logic a);
    q.push_back({c, n, t, a});
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus.result_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result ch=%0d cnt=%0d to=%0d required none",
                 bus.result_ch, bus.result_cnt, bus.result_timeout);
      end else begin
        e = q.pop_front();
        if (bus.result_ch !== e.ch || bus.result_timeout !== e.to ||
            (e.any ? (bus.result_cnt == 8'd0)
                   : (bus.result_cnt !== e.cnt))) begin
          errors++;
          $display("FAIL result actual ch=%0d cnt=%0d to=%0d required ch=%0d cnt=%0d%s to=%0d",
                   bus.result_ch, bus.result_cnt, bus.result_timeout,
                   e.ch, e.cnt, e.any ? "(any>0)" : "", e.to);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_trig(input int c, input logic v);
    int n = 0;
    while (trig[c] !== v && n < 1000) begin
      cyc(1);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL wait_trig%0d actual=%b required=%b", c, trig[c], v);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 2000) begin
      cyc(1);
      n++;
    end
    chk({nm, "_busy_fall"}, 32'(n < 2000), 32'd1);
    cyc(2);
    chk({nm, "_all_results"}, 32'(q.size()), 32'd0);
  endtask

  task automatic pulse_echo(input int c, input int dly, input int len);
    cyc(dly);
    echo[c] = 1'b1;
    cyc(len);
    echo[c] = 1'b0;
  endtask

  initial begin
    logic bad;
    int   n;
    reset     = 1'b0;
    echo      = 2'b00;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    #12;
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.result_valid), 32'd0);
    chk("rst_cnt", 32'(bus.result_cnt), 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(1);

    // idle after reset
    bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (trig != 2'b00 || bus.busy || bus.result_valid) bad = 1'b1;
    end
    cyc(1);
    chk("idle_200", 32'(bad), 32'd0);

    // single sweep, 20-cycle echo on ch0, ch1 silent
    exp_push(1'b0, 8'd20, 1'b0, 1'b0);
    exp_push(1'b1, 8'd0, 1'b1, 1'b0);
    pulse_start();
    wait_trig(0, 1'b1);
    wait_trig(0, 1'b0);
    pulse_echo(0, 5, 20);
    wait_idle("single");

    // stuck-high echo: no rise, timeout with zero count
    echo[0] = 1'b1;
    cyc(5);
    exp_push(1'b0, 8'd0, 1'b1, 1'b0);
    exp_push(1'b1, 8'd0, 1'b1, 1'b0);
    pulse_start();
    wait_idle("stuck");
    echo[0] = 1'b0;
    cyc(5);

    // rise that never falls: timeout with non-zero count
    exp_push(1'b0, 8'd0, 1'b1, 1'b1);
    exp_push(1'b1, 8'd0, 1'b1, 1'b0);
    pulse_start();
    wait_trig(0, 1'b1);
    wait_trig(0, 1'b0);
    cyc(5);
    echo[0] = 1'b1;
    wait_idle("nofall");
    echo[0] = 1'b0;
    cyc(5);

    // continuous mode, two full sweeps then stop
    exp_push(1'b0, 8'd10, 1'b0, 1'b0);
    exp_push(1'b1, 8'd30, 1'b0, 1'b0);
    exp_push(1'b0, 8'd10, 1'b0, 1'b0);
    exp_push(1'b1, 8'd30, 1'b0, 1'b0);
    bus.mode = 1'b1;
    pulse_start();
    for (int it = 0; it < 2; it++) begin
      for (int c = 0; c < 2; c++) begin
        wait_trig(c, 1'b1);
        if (it == 1 && c == 1) bus.mode = 1'b0;
        wait_trig(c, 1'b0);
        pulse_echo(c, 5, (c == 1) ? 30 : 10);
      end
    end
    wait_idle("cont");

    // reset during MEAS aborts silently
    pulse_start();
    wait_trig(0, 1'b1);
    wait_trig(0, 1'b0);
    cyc(5);
    echo[0] = 1'b1;
    cyc(10);
    reset = 1'b0;
    #2;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_trig", 32'(trig), 32'd0);
    chk("mid_rst_ch", 32'(bus.result_ch), 32'd0);
    chk("mid_rst_to", 32'(bus.result_timeout), 32'd0);
    echo[0] = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(5);
    exp_push(1'b0, 8'd0, 1'b1, 1'b0);
    exp_push(1'b1, 8'd0, 1'b1, 1'b0);
    pulse_start();
    n = 0;
    while (trig == 2'b00 && n < 50) begin
      cyc(1);
      n++;
    end
    chk("first_trig_after_rst", 32'(trig), 32'd1);
    wait_idle("post_rst");

    // start during GAP ignored, ch1 echo while ch0 selected ignored
    exp_push(1'b0, 8'd12, 1'b0, 1'b0);
    exp_push(1'b1, 8'd0, 1'b1, 1'b0);
    pulse_start();
    wait_trig(0, 1'b1);
    wait_trig(0, 1'b0);
    pulse_echo(1, 2, 8);
    pulse_echo(0, 5, 12);
    n = 0;
    while (bus.result_valid !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("gap_reached", 32'(n < 200), 32'd1);
    cyc(1);
    pulse_start();
    wait_idle("gap_start");
    bad = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (bus.busy || trig != 2'b00) bad = 1'b1;
    end
    chk("no_extra_sweep", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
